// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-cache to off-chip line memory interface.
package cpu_mem_pkg;
  localparam int LINE_W        = 256;
  localparam int ADDR_W        = 32;
  localparam int LINE_OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;
endpackage

// File: rtl/mem_latency_ctr.sv
// 8-bit load/decrement counter; tc flags the last busy cycle (count==1).
module mem_latency_ctr (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [7:0] count,
  output logic       tc
);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign tc = (count == 8'd1);

endmodule

// File: rtl/line_data_memory.sv
// Fixed-latency, single-outstanding 256-bit line memory behind the data cache.
// Optional LINE_MEM_ADDR_CHECK_EN adds err_o and suppresses out-of-range writes.
module line_data_memory
  import cpu_mem_pkg::*;
#(
  parameter int LINE_W  = cpu_mem_pkg::LINE_W,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
`ifdef LINE_MEM_ADDR_CHECK_EN
  output logic              err_o,
`endif
  output logic [LINE_W-1:0] data_o
);

  localparam int IDX_W = $clog2(DEPTH);

  reg [LINE_W-1:0] mem [0:DEPTH-1];

  state_t            state;
  state_t            state_nxt;
  logic              req_write;
  logic              req_err;
  logic [IDX_W-1:0]  req_idx;
  logic [LINE_W-1:0] req_data;

  logic [IDX_W-1:0]  addr_idx;
  logic              addr_err;
  logic              accept;
  logic              enter_ack;
  logic              cur_write;
  logic              cur_err;
  logic [IDX_W-1:0]  cur_idx;
  logic [7:0]        ctr_count;
  logic              ctr_tc;

  assign addr_idx = addr_i[LINE_OFFSET_W +: IDX_W];

`ifdef LINE_MEM_ADDR_CHECK_EN
  assign addr_err = |addr_i[ADDR_W-1:LINE_OFFSET_W+IDX_W];
  assign err_o    = (state == ACK) && req_err;
  logic addr_unused;
  assign addr_unused = ^{addr_i[LINE_OFFSET_W-1:0], ctr_count};
`else
  assign addr_err = 1'b0;
  logic addr_unused;
  assign addr_unused = ^{addr_i[ADDR_W-1:LINE_OFFSET_W+IDX_W],
                         addr_i[LINE_OFFSET_W-1:0], ctr_count};
`endif

  assign accept = (state == IDLE) && enable_i;

  mem_latency_ctr u_ctr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (accept),
    .load_val (8'(LATENCY - 1)),
    .dec      (state == BUSY),
    .count    (ctr_count),
    .tc       (ctr_tc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable_i) state_nxt = (LATENCY == 1) ? ACK : BUSY;
      BUSY: if (ctr_tc) state_nxt = ACK;
      ACK:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY==1 the request goes straight from IDLE to ACK, so the
  // read must use the live inputs rather than the latched copy.
  assign enter_ack = (state_nxt == ACK) && (state != ACK);
  assign cur_write = (state == IDLE) ? write_i  : req_write;
  assign cur_err   = (state == IDLE) ? addr_err : req_err;
  assign cur_idx   = (state == IDLE) ? addr_idx : req_idx;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      req_write <= 1'b0;
      req_err   <= 1'b0;
      req_idx   <= '0;
      req_data  <= '0;
      data_o    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_write <= write_i;
        req_err   <= addr_err;
        req_idx   <= addr_idx;
        req_data  <= data_i;
      end
      if (enter_ack && !cur_write && !cur_err) begin
        data_o <= mem[cur_idx];
      end
    end
  end

  // The array has no reset; a write commits only on the ACK edge.
  always_ff @(posedge clk_i) begin
    if (rst_i && (state == ACK) && req_write && !req_err) begin
      mem[req_idx] <= req_data;
    end
  end

  assign ack_o = (state == ACK);

endmodule

// File: tb/tb_line_data_memory.sv
// Directed self-checking bench for line_data_memory (LATENCY=10, DEPTH=512).
module tb_line_data_memory;

  logic         clk_i;
  logic         rst_i;
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_o;
  logic [255:0] data_o;
`ifdef LINE_MEM_ADDR_CHECK_EN
  logic         err_o;
`endif

  int n_cmp;
  int n_bad;

  logic [255:0] pat_a5;
  logic [255:0] pat_beef;
  logic [255:0] pat_55;

  line_data_memory #(.LINE_W(256), .DEPTH(512), .LATENCY(10)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .ack_o    (ack_o),
`ifdef LINE_MEM_ADDR_CHECK_EN
    .err_o    (err_o),
`endif
    .data_o   (data_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic start_req(input bit we, input logic [31:0] a,
                           input logic [255:0] d, input bit hold);
    @(negedge clk_i);
    enable_i = 1'b1;
    write_i  = we;
    addr_i   = a;
    data_i   = d;
    @(posedge clk_i);
    #1;
    if (!hold) enable_i = 1'b0;
  endtask

  task automatic wait_ack(input int limit, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < limit) begin
      @(negedge clk_i);
      cycles++;
      if (ack_o === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_i    = 1'b0;
    enable_i = 1'b1;
    write_i  = 1'b0;
    addr_i   = 32'h40;
    data_i   = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_cmp++;
      if (ack_o !== 1'b0) begin
        n_bad++; $display("FAIL reset_ack[%0d]: got %b want 0", i, ack_o);
      end
      n_cmp++;
      if (data_o !== 256'h0) begin
        n_bad++; $display("FAIL reset_data[%0d]: got %h want 0", i, data_o);
      end
    end
    rst_i    = 1'b1;
    enable_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (ack_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_release_ack: got %b want 0", ack_o);
    end
  endtask

  task automatic test_preload;
    int  cyc;
    bit  seen;
    logic [31:0]  addrs [3];
    logic [255:0] vals  [3];
    addrs[0] = 32'h40; vals[0] = pat_a5;
    addrs[1] = 32'h20; vals[1] = pat_beef;
    addrs[2] = 32'h00; vals[2] = pat_55;
    for (int i = 0; i < 3; i++) begin
      start_req(1'b1, addrs[i], vals[i], 1'b0);
      wait_ack(20, cyc, seen);
      n_cmp++;
      if (cyc != 10 || !seen) begin
        n_bad++; $display("FAIL write_latency[%0d]: got %0d cycles (seen=%0b) want 10", i, cyc, seen);
      end
      n_cmp++;
      if (data_o !== 256'h0) begin
        n_bad++; $display("FAIL write_keeps_data[%0d]: got %h want 0", i, data_o);
      end
    end
  endtask

  task automatic test_read;
    int cyc;
    bit seen;
    start_req(1'b0, 32'h40, '0, 1'b0);
    wait_ack(20, cyc, seen);
    n_cmp++;
    if (cyc != 10 || !seen) begin
      n_bad++; $display("FAIL read_latency: got %0d cycles (seen=%0b) want 10", cyc, seen);
    end
    n_cmp++;
    if (data_o !== pat_a5) begin
      n_bad++; $display("FAIL read_data: got %h want %h", data_o, pat_a5);
    end
    @(negedge clk_i);
    n_cmp++;
    if (ack_o !== 1'b0) begin
      n_bad++; $display("FAIL read_ack_single: got %b want 0", ack_o);
    end
    repeat (4) @(negedge clk_i);
    n_cmp++;
    if (data_o !== pat_a5) begin
      n_bad++; $display("FAIL read_data_hold: got %h want %h", data_o, pat_a5);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit seen;
    start_req(1'b1, 32'h80, 256'h1234, 1'b1);
    wait_ack(20, cyc, seen);
    n_cmp++;
    if (cyc != 10 || !seen) begin
      n_bad++; $display("FAIL b2b_write_latency: got %0d cycles (seen=%0b) want 10", cyc, seen);
    end
    n_cmp++;
    if (data_o !== pat_a5) begin
      n_bad++; $display("FAIL b2b_write_keeps_data: got %h want %h", data_o, pat_a5);
    end
    write_i = 1'b0;
    wait_ack(20, cyc, seen);
    enable_i = 1'b0;
    n_cmp++;
    if (cyc != 11 || !seen) begin
      n_bad++; $display("FAIL b2b_ack_gap: got %0d cycles (seen=%0b) want 11", cyc, seen);
    end
    n_cmp++;
    if (data_o !== 256'h1234) begin
      n_bad++; $display("FAIL b2b_read_data: got %h want 1234", data_o);
    end
  endtask

  task automatic test_mid_change;
    int cyc;
    bit seen;
    start_req(1'b0, 32'h40, '0, 1'b0);
    addr_i  = 32'h80;
    write_i = 1'b1;
    wait_ack(20, cyc, seen);
    n_cmp++;
    if (cyc != 10 || !seen) begin
      n_bad++; $display("FAIL mid_latency: got %0d cycles (seen=%0b) want 10", cyc, seen);
    end
    n_cmp++;
    if (data_o !== pat_a5) begin
      n_bad++; $display("FAIL mid_data: got %h want %h", data_o, pat_a5);
    end
  endtask

  task automatic test_reset_mid_write;
    int cyc;
    bit seen;
    start_req(1'b1, 32'h20, 256'hDEAD, 1'b0);
    repeat (4) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (ack_o !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_ack: got %b want 0", ack_o);
    end
    rst_i = 1'b1;
    wait_ack(15, cyc, seen);
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_no_ack: got ack after %0d cycles want none", cyc);
    end
    start_req(1'b0, 32'h20, '0, 1'b0);
    wait_ack(20, cyc, seen);
    n_cmp++;
    if (cyc != 10 || !seen) begin
      n_bad++; $display("FAIL rst_mid_read_latency: got %0d cycles (seen=%0b) want 10", cyc, seen);
    end
    n_cmp++;
    if (data_o !== pat_beef) begin
      n_bad++; $display("FAIL rst_mid_mem_kept: got %h want %h", data_o, pat_beef);
    end
  endtask

  task automatic test_addr_high;
    int cyc;
    bit seen;
    logic [255:0] exp_line;
    start_req(1'b1, 32'h0000_4000, 256'h77, 1'b0);
    wait_ack(20, cyc, seen);
    n_cmp++;
    if (cyc != 10 || !seen) begin
      n_bad++; $display("FAIL high_latency: got %0d cycles (seen=%0b) want 10", cyc, seen);
    end
`ifdef LINE_MEM_ADDR_CHECK_EN
    n_cmp++;
    if (err_o !== 1'b1) begin
      n_bad++; $display("FAIL high_err: got %b want 1", err_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_bad++; $display("FAIL high_err_clear: got %b want 0", err_o);
    end
    exp_line = pat_55;
`else
    exp_line = 256'h77;
`endif
    start_req(1'b0, 32'h0, '0, 1'b0);
    wait_ack(20, cyc, seen);
    n_cmp++;
    if (data_o !== exp_line) begin
      n_bad++; $display("FAIL high_line0: got %h want %h", data_o, exp_line);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    pat_a5   = {32{8'hA5}};
    pat_beef = 256'hBEEF;
    pat_55   = 256'h55;
    rst_i    = 1'b0;
    enable_i = 1'b0;
    write_i  = 1'b0;
    addr_i   = '0;
    data_i   = '0;
    test_reset();
    test_preload();
    test_read();
    test_back_to_back();
    test_mid_change();
    test_reset_mid_write();
    test_addr_high();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
